// File: rtl/vrf_pkg.sv
// vrf_pkg: shared definitions for the vector register file slice.
//   VRF_ADDR_W      - address width, fixed at 5 so the issue interface
//                     keeps the same port width for any NUM_REGS
//   vrf_addr_t      - register address type
//   vrf_num_lanes() - number of write lanes for a register/lane width pair
//   vrf_addr_ok()   - range check of an address against NUM_REGS
package vrf_pkg;

    localparam int VRF_ADDR_W = 5;

    typedef logic [VRF_ADDR_W-1:0] vrf_addr_t;

    function automatic int vrf_num_lanes(input int reg_width, input int lane_width);
        return reg_width / lane_width;
    endfunction

    // Lane/range helper: NUM_REGS need not be a power of two, so a 5-bit
    // address can point past the end of the array.
    function automatic logic vrf_addr_ok(input vrf_addr_t a, input int num_regs);
        return int'(a) < num_regs;
    endfunction

endpackage

// File: rtl/vec_register_file_if.sv
// vec_register_file_if: issue/writeback bus of the vector register file.
//   A1/A2, RD1/RD2, BUSY1/BUSY2 - two combinational read ports with hazard flags
//   WE3/A3/WD3/WM3              - lane-masked write port (ALU writeback)
//   RSV/RSV_A                   - scoreboard reservation from issue
//   ERR                         - sticky out-of-range access flag
// modport master: issue/writeback side; modport slave: the register file.
interface vec_register_file_if
    import vrf_pkg::*;
#(
    parameter int REG_WIDTH  = 256,
    parameter int LANE_WIDTH = 32
);
    localparam int NUM_LANES = vrf_num_lanes(REG_WIDTH, LANE_WIDTH);

    vrf_addr_t              A1;
    vrf_addr_t              A2;
    logic [REG_WIDTH-1:0]   RD1;
    logic [REG_WIDTH-1:0]   RD2;
    logic                   BUSY1;
    logic                   BUSY2;
    logic                   WE3;
    vrf_addr_t              A3;
    logic [REG_WIDTH-1:0]   WD3;
    logic [NUM_LANES-1:0]   WM3;
    logic                   RSV;
    vrf_addr_t              RSV_A;
    logic                   ERR;

    modport master (
        output A1, A2, WE3, A3, WD3, WM3, RSV, RSV_A,
        input  RD1, RD2, BUSY1, BUSY2, ERR
    );

    modport slave (
        input  A1, A2, WE3, A3, WD3, WM3, RSV, RSV_A,
        output RD1, RD2, BUSY1, BUSY2, ERR
    );

endinterface

// File: rtl/vrf_scoreboard.sv
// vrf_scoreboard: one pending-write bit per vector register.
//   clk, rst      - clock, synchronous active-low reset
//   rsv, rsv_a    - reservation (already range-qualified by the caller)
//   rel, rel_a    - release from a committed write (range-qualified)
//   rd_a1, rd_a2  - lookup addresses
//   busy1, busy2  - pending flags for rd_a1 / rd_a2
// With VRF_BYPASS_EN defined, a same-cycle release is forwarded to the busy
// outputs unless a same-cycle reservation of that register re-arms it.
module vrf_scoreboard
    import vrf_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rsv,
    input  vrf_addr_t rsv_a,
    input  logic      rel,
    input  vrf_addr_t rel_a,
    input  vrf_addr_t rd_a1,
    input  vrf_addr_t rd_a2,
    output logic      busy1,
    output logic      busy2
);

    logic [NUM_REGS-1:0] sb;

    // Reservation has priority: the retiring producer releases while the
    // newly issued one claims the same register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sb <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (rsv && rsv_a == vrf_addr_t'(r))
                    sb[r] <= 1'b1;
                else if (rel && rel_a == vrf_addr_t'(r))
                    sb[r] <= 1'b0;
            end
        end
    end

    // Loop lookup keeps out-of-range addresses reading as not busy.
    function automatic logic sb_at(input vrf_addr_t a);
        logic b;
        b = 1'b0;
        for (int r = 0; r < NUM_REGS; r++)
            if (a == vrf_addr_t'(r)) b = sb[r];
        return b;
    endfunction

    always_comb begin
        busy1 = sb_at(rd_a1);
        busy2 = sb_at(rd_a2);
`ifdef VRF_BYPASS_EN
        if (rel && rel_a == rd_a1 && !(rsv && rsv_a == rd_a1)) busy1 = 1'b0;
        if (rel && rel_a == rd_a2 && !(rsv && rsv_a == rd_a2)) busy2 = 1'b0;
`endif
    end

endmodule

// File: rtl/vec_register_file.sv
// vec_register_file: NUM_REGS x REG_WIDTH vector register file with two
// combinational read ports, one lane-masked write port, a pending-write
// scoreboard and a sticky out-of-range error flag.
//   clk  - rising-edge clock
//   rst  - synchronous active-low reset (clears data, scoreboard, ERR and
//          overrides any same-cycle write or reserve)
//   bus  - vec_register_file_if.slave (read, write, reserve, ERR)
// Optional: VRF_BYPASS_EN forwards a same-cycle write to RD1/RD2 (lane-merged
// over the stored value) and its scoreboard release to BUSY1/BUSY2.
module vec_register_file
    import vrf_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int REG_WIDTH  = 256,
    parameter int LANE_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    vec_register_file_if.slave  bus
);

    localparam int NUM_LANES = vrf_num_lanes(REG_WIDTH, LANE_WIDTH);

    logic [REG_WIDTH-1:0] mem [NUM_REGS];
    logic                 we_ok;
    logic                 rsv_ok;
    logic                 err_q;
    logic [REG_WIDTH-1:0] rd1;
    logic [REG_WIDTH-1:0] rd2;

    assign we_ok  = bus.WE3 && vrf_addr_ok(bus.A3, NUM_REGS);
    assign rsv_ok = bus.RSV && vrf_addr_ok(bus.RSV_A, NUM_REGS);

    // Lanes with mask=1 take the new data, the rest keep the old value.
    function automatic logic [REG_WIDTH-1:0] lane_merge(
        input logic [REG_WIDTH-1:0] old_v,
        input logic [REG_WIDTH-1:0] new_v,
        input logic [NUM_LANES-1:0] mask
    );
        logic [REG_WIDTH-1:0] m;
        m = old_v;
        for (int l = 0; l < NUM_LANES; l++)
            if (mask[l]) m[l*LANE_WIDTH +: LANE_WIDTH] = new_v[l*LANE_WIDTH +: LANE_WIDTH];
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                if (we_ok && bus.A3 == vrf_addr_t'(r))
                    mem[r] <= lane_merge(mem[r], bus.WD3, bus.WM3);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            err_q <= 1'b0;
        else if ((bus.WE3 && !we_ok) || (bus.RSV && !rsv_ok))
            err_q <= 1'b1;
    end

    function automatic logic [REG_WIDTH-1:0] rd_at(input vrf_addr_t a);
        logic [REG_WIDTH-1:0] v;
        v = '0;
        for (int r = 0; r < NUM_REGS; r++)
            if (a == vrf_addr_t'(r)) v = mem[r];
        return v;
    endfunction

    always_comb begin
        rd1 = rd_at(bus.A1);
        rd2 = rd_at(bus.A2);
`ifdef VRF_BYPASS_EN
        if (we_ok && bus.A3 == bus.A1) rd1 = lane_merge(rd1, bus.WD3, bus.WM3);
        if (we_ok && bus.A3 == bus.A2) rd2 = lane_merge(rd2, bus.WD3, bus.WM3);
`endif
    end

    assign bus.RD1 = rd1;
    assign bus.RD2 = rd2;
    assign bus.ERR = err_q;

    vrf_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
        .clk   (clk),
        .rst   (rst),
        .rsv   (rsv_ok),
        .rsv_a (bus.RSV_A),
        .rel   (we_ok),
        .rel_a (bus.A3),
        .rd_a1 (bus.A1),
        .rd_a2 (bus.A2),
        .busy1 (bus.BUSY1),
        .busy2 (bus.BUSY2)
    );

endmodule

// File: tb/tb_vec_register_file.sv
// tb_vec_register_file: directed vectors with hand-computed expectations for
// vec_register_file built with NUM_REGS=20 (so addresses 20..31 are out of
// range). Expectations for the same-cycle forwarding case follow VRF_BYPASS_EN.
module tb_vec_register_file;
    import vrf_pkg::*;

    localparam int NR = 20;
    localparam int RW = 256;
    localparam int LW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    vec_register_file_if #(.REG_WIDTH(RW), .LANE_WIDTH(LW)) bus ();

    vec_register_file #(.NUM_REGS(NR), .REG_WIDTH(RW), .LANE_WIDTH(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock edge, then drop back off the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.WE3 = 1'b0; bus.RSV = 1'b0; bus.WM3 = '0; bus.WD3 = '0;
    endtask

    logic [RW-1:0] v_merge;
    logic [RW-1:0] v_byp;

    initial begin
        bus.A1 = '0; bus.A2 = '0; bus.A3 = '0; bus.RSV_A = '0;
        idle();

        // 1: reset then read
        step();
        rst = 1'b1;
        bus.A1 = 5'd3; bus.A2 = 5'd31;
        #1;
        chk("rst_rd1",   bus.RD1, '0);
        chk("rst_rd2",   bus.RD2, '0);
        chk("rst_busy1", RW'(bus.BUSY1), '0);
        chk("rst_busy2", RW'(bus.BUSY2), '0);
        chk("rst_err",   RW'(bus.ERR), '0);

        // 2: full write, then lower-4-lane write
        bus.WE3 = 1'b1; bus.A3 = 5'd3; bus.WD3 = {8{32'hAAAABEEF}}; bus.WM3 = 8'hFF;
        step();
        bus.WD3 = {8{32'hCAFEBABE}}; bus.WM3 = 8'h0F;
        step();
        idle();
        #1;
        v_merge = {{4{32'hAAAABEEF}}, {4{32'hCAFEBABE}}};
        chk("mask_merge", bus.RD1, v_merge);
        // empty mask writes nothing
        bus.WE3 = 1'b1; bus.A3 = 5'd3; bus.WD3 = '1; bus.WM3 = 8'h00;
        step();
        idle();
        #1;
        chk("mask_zero", bus.RD1, v_merge);

        // 3: scoreboard
        bus.A2 = 5'd7;
        bus.RSV = 1'b1; bus.RSV_A = 5'd7;
        step();
        idle();
        #1;
        chk("sb_set", RW'(bus.BUSY2), RW'(1'b1));
        chk("sb_other", RW'(bus.BUSY1), '0);
        bus.WE3 = 1'b1; bus.A3 = 5'd7; bus.WM3 = 8'h00;
        #1;
`ifdef VRF_BYPASS_EN
        chk("sb_rel_same", RW'(bus.BUSY2), '0);
`else
        chk("sb_rel_same", RW'(bus.BUSY2), RW'(1'b1));
`endif
        step();
        idle();
        #1;
        chk("sb_rel", RW'(bus.BUSY2), '0);
        // first reserve, then reserve+release together
        bus.RSV = 1'b1; bus.RSV_A = 5'd7;
        step();
        bus.WE3 = 1'b1; bus.A3 = 5'd7;
        #1;
        chk("sb_both_same", RW'(bus.BUSY2), RW'(1'b1));
        step();
        idle();
        #1;
        chk("sb_both", RW'(bus.BUSY2), RW'(1'b1));
        // re-reserve a busy register: still busy, no error
        bus.RSV = 1'b1; bus.RSV_A = 5'd7;
        step();
        idle();
        bus.WE3 = 1'b1; bus.A3 = 5'd7;
        step();
        idle();
        #1;
        chk("sb_rerel", RW'(bus.BUSY2), '0);
        chk("sb_noerr", RW'(bus.ERR), '0);

        // 4: out of range with NUM_REGS=20; last valid register first
        bus.WE3 = 1'b1; bus.A3 = 5'd19; bus.WD3 = {8{32'h19191919}}; bus.WM3 = 8'hFF;
        step();
        idle();
        bus.A1 = 5'd19;
        #1;
        chk("oor_top_rd", bus.RD1, {8{32'h19191919}});
        chk("oor_top_err", RW'(bus.ERR), '0);
        bus.WE3 = 1'b1; bus.A3 = 5'd25; bus.WD3 = '1; bus.WM3 = 8'hFF;
        step();
        idle();
        #1;
        chk("oor_err", RW'(bus.ERR), RW'(1'b1));
        bus.A1 = 5'd25; bus.A2 = 5'd3;
        #1;
        chk("oor_rd", bus.RD1, '0);
        chk("oor_busy", RW'(bus.BUSY1), '0);
        chk("oor_keep3", bus.RD2, v_merge);
        bus.A1 = 5'd19;
        step(); step();
        chk("oor_keep19", bus.RD1, {8{32'h19191919}});
        chk("oor_sticky", RW'(bus.ERR), RW'(1'b1));

        // 5: same-cycle forwarding into register 5 (still zero)
        bus.A1 = 5'd5;
        bus.WE3 = 1'b1; bus.A3 = 5'd5; bus.WD3 = {8{32'h12345678}}; bus.WM3 = 8'h01;
        #1;
        v_byp = {224'h0, 32'h12345678};
`ifdef VRF_BYPASS_EN
        chk("byp_same", bus.RD1, v_byp);
`else
        chk("byp_same", bus.RD1, '0);
`endif
        step();
        idle();
        #1;
        chk("byp_next", bus.RD1, v_byp);

        // 6: reset mid-operation discards write and reserve
        bus.WE3 = 1'b1; bus.A3 = 5'd2; bus.WD3 = '1; bus.WM3 = 8'hFF;
        bus.RSV = 1'b1; bus.RSV_A = 5'd4;
        rst = 1'b0;
        step();
        rst = 1'b1;
        idle();
        bus.A1 = 5'd2; bus.A2 = 5'd4;
        #1;
        chk("mrst_rd", bus.RD1, '0);
        chk("mrst_busy", RW'(bus.BUSY2), '0);
        chk("mrst_err", RW'(bus.ERR), '0);
        bus.A1 = 5'd3;
        #1;
        chk("mrst_clr3", bus.RD1, '0);

        // out-of-range reserve sets ERR too
        bus.RSV = 1'b1; bus.RSV_A = 5'd20;
        step();
        idle();
        #1;
        chk("oor_rsv_err", RW'(bus.ERR), RW'(1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
